// File: rtl/fetch_sequencer_if.sv
// Decode-side handshake bundle: buffered instruction, its PC, valid/ready.
// Latency: none (wires only).
// Backpressure: the slave holds out_ready low; the master keeps its payload stable.
interface fetch_sequencer_if;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   modport master (output out_valid, output out_instr, output out_pc, input out_ready);
   modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC and reads a combinational instruction
// memory into a one-entry buffer offered to decode; redirect, halt and PC wrap.
// Latency: one cycle from address to out_valid, one instruction per cycle.
// Backpressure: out_ready low freezes the buffer and PC.
// Optional build macro FETCH_ALIGN_CHECK_EN adds a sticky FAULT state for misaligned redirects.
module fetch_sequencer #(
   parameter int          ADDR_W   = 8,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   output logic [31:0]              o_imem_addr,
   input  logic [31:0]              i_imem_data,
   fetch_sequencer_if.master        out_if,
   input  logic                     i_redirect_valid,
   input  logic [31:0]              i_redirect_pc,
   input  logic                     i_halt_req,
   output logic                     o_halted,
   output logic                     o_fault
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HALT  = 2'd1
`ifdef FETCH_ALIGN_CHECK_EN
      ,S_FAULT = 2'd2
`endif
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_pc;
   logic                r_out_valid;
   logic [31:0]         r_out_instr;
   logic [ADDR_W-1:0]   r_out_pc;

   logic [ADDR_W-1:0]   w_target;
   logic                w_redirect;
   logic                w_cap;
   logic                w_xfer;

`ifdef FETCH_ALIGN_CHECK_EN
   logic                w_misalign;
   logic                w_unused_ok;

   // Target keeps its low bits so a faulting PC stays visible on the address bus.
   assign w_target    = i_redirect_pc[ADDR_W-1:0];
   assign w_misalign  = (i_redirect_pc[1:0] != 2'b00);
   assign w_redirect  = i_redirect_valid && (r_state != S_FAULT);
   assign w_unused_ok = ^i_redirect_pc[31:ADDR_W];
`else
   logic                w_unused_ok;

   // Without the check, low bits are simply dropped so the PC stays word-aligned.
   assign w_target    = {i_redirect_pc[ADDR_W-1:2], 2'b00};
   assign w_redirect  = i_redirect_valid;
   assign w_unused_ok = ^{i_redirect_pc[31:ADDR_W], i_redirect_pc[1:0]};
`endif

   assign w_xfer = r_out_valid && out_if.out_ready;
   assign w_cap  = (r_state == S_FETCH) && !i_redirect_valid && !i_halt_req &&
                   (!r_out_valid || out_if.out_ready);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: halt_req level selects HALT/FETCH; a misaligned redirect traps.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_FETCH, S_HALT: w_state_next = i_halt_req ? S_HALT : S_FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
         S_FAULT:         w_state_next = S_FAULT;
`endif
         default:         w_state_next = S_FETCH;
      endcase
`ifdef FETCH_ALIGN_CHECK_EN
      if (w_redirect && w_misalign) begin
         w_state_next = S_FAULT;
      end
`endif
   end

   // Outputs decoded from state and the buffer registers.
   always_comb begin
      o_imem_addr      = {{(32-ADDR_W){1'b0}}, r_pc};
      out_if.out_valid = r_out_valid;
      out_if.out_instr = r_out_instr;
      out_if.out_pc    = {{(32-ADDR_W){1'b0}}, r_out_pc};
      o_halted         = (r_state == S_HALT) && !r_out_valid;
`ifdef FETCH_ALIGN_CHECK_EN
      o_fault          = (r_state == S_FAULT);
`else
      o_fault          = 1'b0;
`endif
   end

   // PC and output buffer: redirect flushes, capture refills, transfer drains.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pc        <= RESET_PC[ADDR_W-1:0];
         r_out_valid <= 1'b0;
         r_out_instr <= 32'h0;
         r_out_pc    <= '0;
      end else if (w_redirect) begin
         r_pc        <= w_target;
         r_out_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      end else if (r_state == S_FAULT) begin
         r_out_valid <= 1'b0;
`endif
      end else if (w_cap) begin
         r_out_instr <= i_imem_data;
         r_out_pc    <= r_pc;
         r_out_valid <= 1'b1;
         r_pc        <= r_pc + ADDR_W'(4);
      end else if (w_xfer) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule
